pwm_ramp_ctrl: RTL

Sequencing controller for a PWM generator on each motor channel of the car. It accepts target-duty commands over a valid/ready handshake and owns the generator's `period`/`duty` inputs. It changes duty only at PWM frame boundaries, ramping toward each target by a commanded step per frame. A frame-count watchdog and an emergency stop force the motor to zero duty.

---
 rtl/pwm_ramp_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: sequencing controller in front of a PWM generator.
// It takes target-duty commands over a valid/ready handshake. Duty changes only on frame wraps,
// where it ramps toward the target by a commanded step per frame. A frame-count watchdog and a
// level emergency stop force the output duty to zero.
//
// Ports:
//   clk, rst         system clock, asynchronous active-high reset
//   cfg_period       frame length minus 1, loaded on command accept in IDLE
//   cmd_valid/ready  command handshake (ready is combinational from state and estop)
//   cmd_duty         target duty in high cycles per frame
//   cmd_step         duty change per frame (0 = jump to target at next wrap)
//   estop            level emergency stop
//   period_o, duty_o generator period/duty inputs
//   frame_tick       one-cycle pulse in the first cycle of each frame
//   busy, at_target  state is RAMP / HOLD
//   wdog_trip        sticky watchdog indication, cleared by an accepted command
module pwm_ramp_ctrl #(
  parameter int unsigned N           = 32,
  parameter int unsigned DEF_PERIOD  = 999,
  parameter int unsigned WDOG_FRAMES = 50
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] cfg_period,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [N-1:0] cmd_duty,
  input  logic [N-1:0] cmd_step,
  input  logic         estop,
  output logic [N-1:0] period_o,
  output logic [N-1:0] duty_o,
  output logic         frame_tick,
  output logic         busy,
  output logic         at_target,
  output logic         wdog_trip
);

  localparam logic [N-1:0] DefPeriod  = N'(DEF_PERIOD);
  localparam logic [31:0]  WdogFrames = 32'(WDOG_FRAMES);
  localparam bit           WdogEn     = (WDOG_FRAMES != 0);

  typedef enum logic [1:0] {StIdle, StRamp, StHold, StStop} state_e;

  state_e state_q, state_d;

  logic [N-1:0] fc_q, fc_d;
  logic [N-1:0] period_q, period_d;
  logic [N-1:0] duty_q, duty_d;
  logic [N-1:0] target_q, target_d;
  logic [N-1:0] step_q, step_d;
  logic [31:0]  wdog_cnt_q, wdog_cnt_d;
  logic         wdog_trip_q, wdog_trip_d;
  logic         frame_tick_q, frame_tick_d;
  logic         busy_q, busy_d;
  logic         at_target_q, at_target_d;

  // Event decode, in edge priority order: estop > watchdog > command > ramp.
  logic         wrap;
  logic         accept;
  logic         in_run;
  logic         wdog_fire;
  logic         take_cmd;
  logic         idle_load;
  logic         ramp_upd;

  assign wrap      = (fc_q == period_q);
  assign accept    = cmd_valid && cmd_ready;
  assign in_run    = (state_q == StRamp) || (state_q == StHold);
  assign wdog_fire = WdogEn && !estop && in_run && wrap && ((wdog_cnt_q + 32'd1) == WdogFrames);
  assign take_cmd  = accept && !wdog_fire;
  assign idle_load = take_cmd && (state_q == StIdle);
  assign ramp_upd  = !estop && !wdog_fire && !take_cmd && (state_q == StRamp) && wrap;

  // Target clamp against the period in force after this edge (new one on an IDLE accept).
  logic [N-1:0] eff_period;
  logic [N:0]   lim_x;
  logic [N-1:0] cmd_target;

  always_comb begin
    eff_period = idle_load ? cfg_period : period_q;
    lim_x      = {1'b0, eff_period} + {{N{1'b0}}, 1'b1};
    cmd_target = cmd_duty;
    if ({1'b0, cmd_duty} > lim_x) begin
      // lim_x is below cmd_duty here, so it fits in N bits.
      cmd_target = lim_x[N-1:0];
    end
  end

  // One ramp step toward target; N+1-bit arithmetic avoids wrap-around.
  logic [N:0]   sum_x;
  logic [N:0]   diff_x;
  logic [N-1:0] ramp_duty;

  always_comb begin
    sum_x     = {1'b0, duty_q} + {1'b0, step_q};
    diff_x    = {1'b0, duty_q} - {1'b0, target_q};
    ramp_duty = target_q;
    if (step_q != '0) begin
      if (duty_q < target_q) begin
        ramp_duty = (sum_x >= {1'b0, target_q}) ? target_q : sum_x[N-1:0];
      end else if (duty_q > target_q) begin
        ramp_duty = (diff_x <= {1'b0, step_q}) ? target_q : (duty_q - step_q);
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    if (estop) begin
      state_d = StStop;
    end else if (state_q == StStop) begin
      state_d = StIdle;
    end else if (wdog_fire || take_cmd) begin
      state_d = StRamp;
    end else if (ramp_upd && (ramp_duty == target_q)) begin
      state_d = (target_q == '0) ? StIdle : StHold;
    end
  end

  // FSM: outputs (next values of the registered status flags, plus combinational ready)
  always_comb begin
    cmd_ready    = (state_q != StStop) && !estop;
    busy_d       = (state_d == StRamp);
    at_target_d  = (state_d == StHold);
    // An IDLE-accept restart of the frame counter is not a frame boundary.
    frame_tick_d = wrap && !idle_load;
  end

  // Datapath next-state
  always_comb begin
    fc_d        = wrap ? '0 : fc_q + {{(N-1){1'b0}}, 1'b1};
    period_d    = period_q;
    duty_d      = duty_q;
    target_d    = target_q;
    step_d      = step_q;
    wdog_cnt_d  = wdog_cnt_q;
    wdog_trip_d = wdog_trip_q;

    if (estop) begin
      duty_d     = '0;
      target_d   = '0;
      wdog_cnt_d = '0;
    end else if (wdog_fire) begin
      // Keep the step so the ramp-down rate follows the last command.
      target_d    = '0;
      wdog_cnt_d  = '0;
      wdog_trip_d = 1'b1;
    end else if (take_cmd) begin
      target_d    = cmd_target;
      step_d      = cmd_step;
      wdog_cnt_d  = '0;
      wdog_trip_d = 1'b0;
      if (idle_load) begin
        period_d = cfg_period;
        fc_d     = '0;
      end
    end else begin
      if (ramp_upd) begin
        duty_d = ramp_duty;
      end
      if (in_run && wrap) begin
        wdog_cnt_d = wdog_cnt_q + 32'd1;
      end
    end

    if ((state_d == StIdle) || (state_d == StStop)) begin
      wdog_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_q         <= '0;
      period_q     <= DefPeriod;
      duty_q       <= '0;
      target_q     <= '0;
      step_q       <= '0;
      wdog_cnt_q   <= '0;
      wdog_trip_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
      at_target_q  <= 1'b0;
    end else begin
      fc_q         <= fc_d;
      period_q     <= period_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      step_q       <= step_d;
      wdog_cnt_q   <= wdog_cnt_d;
      wdog_trip_q  <= wdog_trip_d;
      frame_tick_q <= frame_tick_d;
      busy_q       <= busy_d;
      at_target_q  <= at_target_d;
    end
  end

  assign period_o   = period_q;
  assign duty_o     = duty_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;
  assign at_target  = at_target_q;
  assign wdog_trip  = wdog_trip_q;

endmodule
